// File: rtl/cdiv_pkg.sv
// Shared state type and width/constant helpers for the cdiv complex divider.
// CDIV_ROUND_EN adds one guard quotient bit for round-half-away-from-zero results.
package cdiv_pkg;

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

`ifdef CDIV_ROUND_EN
    localparam int GUARD_BITS = 1;
`else
    localparam int GUARD_BITS = 0;
`endif

    // Full-precision product and |B|^2 width for a given component width.
    function automatic int prod_width(input int dw);
        return 2 * dw + 1;
    endfunction

    // Quotient bits produced per division, including the optional guard bit.
    function automatic int div_iters(input int dw);
        return dw + GUARD_BITS;
    endfunction

    function automatic logic [63:0] sat_pos(input int dw);
        return (64'd1 << (dw - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_neg(input int dw);
        return 64'd1 << (dw - 1);
    endfunction

endpackage

// File: rtl/cdiv_udiv_iter.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// Q_W follows CDIV_ROUND_EN through the parent; quotient is valid when done pulses.
module udiv_iter #(
    parameter int DVD_W = 41,
    parameter int DVS_W = 33,
    parameter int Q_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);

    localparam int RW = DVS_W + Q_W;
    localparam int CW = $clog2(Q_W + 1);

    logic [RW-1:0] rem_q;
    logic [RW-1:0] dsr_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q    <= '0;
            dsr_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q    <= RW'(dividend);
                dsr_q    <= RW'(divisor) << (Q_W - 1);
                cnt_q    <= CW'(Q_W);
                busy_q   <= 1'b1;
                quotient <= '0;
            end else if (busy_q) begin
                // Trial subtract of the divisor aligned to the current quotient bit.
                if (rem_q >= dsr_q) begin
                    rem_q    <= rem_q - dsr_q;
                    quotient <= {quotient[Q_W-2:0], 1'b1};
                end else begin
                    quotient <= {quotient[Q_W-2:0], 1'b0};
                end
                dsr_q <= dsr_q >> 1;
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy_q <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cdiv.sv
// Sequential complex divider Y = A*conj(B)/|B|^2 on signed fixed-point operands.
// Define CDIV_ROUND_EN for round-half-away-from-zero (one extra cycle of latency).
module cdiv
    import cdiv_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] A_real,
    input  logic signed [DATA_WIDTH-1:0] A_imag,
    input  logic signed [DATA_WIDTH-1:0] B_real,
    input  logic signed [DATA_WIDTH-1:0] B_imag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic        [DATA_WIDTH-1:0] Y_real,
    output logic        [DATA_WIDTH-1:0] Y_imag,
    output logic                         div_by_zero
);

    localparam int PW    = prod_width(DATA_WIDTH);
    localparam int ITERS = div_iters(DATA_WIDTH);
    localparam int DVD_W = PW + FRAC_BITS + GUARD_BITS;
    localparam int OW    = PW + DATA_WIDTH;
    localparam logic [DATA_WIDTH-1:0] SAT_POS = DATA_WIDTH'(sat_pos(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] SAT_NEG = DATA_WIDTH'(sat_neg(DATA_WIDTH));

    state_t state_q, state_d;
    logic   div_start;

    logic signed [DATA_WIDTH-1:0] a_re_q, a_im_q, b_re_q, b_im_q;

    logic signed [PW-1:0] ar, ai, br, bi;
    logic signed [PW-1:0] nre_c, nim_c;
    logic        [PW-1:0] den_c, nre_mag_c, nim_mag_c;
    logic                 ovf_re_c, ovf_im_c;
    logic     [DVD_W-1:0] dvd_re, dvd_im;

    logic nre_neg_q, nim_neg_q, ovf_re_q, ovf_im_q, den_zero_q;

    logic             done_re, done_im, div_done;
    logic [ITERS-1:0] q_re, q_im;
    logic [DATA_WIDTH-1:0] y_re_c, y_im_c;

    // Products come straight from the captured operands so the dividers can
    // load on the same edge that leaves MULT.
    assign ar = PW'(a_re_q);
    assign ai = PW'(a_im_q);
    assign br = PW'(b_re_q);
    assign bi = PW'(b_im_q);

    assign nre_c = ar * br + ai * bi;
    assign nim_c = ai * br - ar * bi;
    assign den_c = $unsigned(br * br + bi * bi);

    assign nre_mag_c = nre_c[PW-1] ? $unsigned(-nre_c) : $unsigned(nre_c);
    assign nim_mag_c = nim_c[PW-1] ? $unsigned(-nim_c) : $unsigned(nim_c);

    // Quotient would not fit in DATA_WIDTH-1 magnitude bits.
    assign ovf_re_c = (OW'(nre_mag_c) << FRAC_BITS) >= (OW'(den_c) << (DATA_WIDTH - 1));
    assign ovf_im_c = (OW'(nim_mag_c) << FRAC_BITS) >= (OW'(den_c) << (DATA_WIDTH - 1));

    assign dvd_re = DVD_W'(nre_mag_c) << (FRAC_BITS + GUARD_BITS);
    assign dvd_im = DVD_W'(nim_mag_c) << (FRAC_BITS + GUARD_BITS);

    udiv_iter #(.DVD_W(DVD_W), .DVS_W(PW), .Q_W(ITERS)) u_div_re (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (dvd_re),
        .divisor  (den_c),
        .done     (done_re),
        .quotient (q_re)
    );

    udiv_iter #(.DVD_W(DVD_W), .DVS_W(PW), .Q_W(ITERS)) u_div_im (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (dvd_im),
        .divisor  (den_c),
        .done     (done_im),
        .quotient (q_im)
    );

    assign div_done = done_re & done_im;

    function automatic logic [DATA_WIDTH-1:0] form_result(
        input logic [ITERS-1:0] q,
        input logic             neg,
        input logic             ovf,
        input logic             dz,
        input logic             a_neg,
        input logic             a_zero
    );
        logic [ITERS-1:0] mag;
`ifdef CDIV_ROUND_EN
        mag = (q >> 1) + ITERS'(q[0]);
`else
        mag = q;
`endif
        if (dz)
            return a_zero ? '0 : (a_neg ? SAT_NEG : SAT_POS);
        if (ovf || ((mag >> (DATA_WIDTH - 1)) != '0))
            return neg ? SAT_NEG : SAT_POS;
        return neg ? -mag[DATA_WIDTH-1:0] : mag[DATA_WIDTH-1:0];
    endfunction

    assign y_re_c = form_result(q_re, nre_neg_q, ovf_re_q, den_zero_q,
                                a_re_q[DATA_WIDTH-1], a_re_q == '0);
    assign y_im_c = form_result(q_im, nim_neg_q, ovf_im_q, den_zero_q,
                                a_im_q[DATA_WIDTH-1], a_im_q == '0);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        unique case (state_q)
            IDLE: if (in_valid) state_d = MULT;
            MULT: begin
                div_start = 1'b1;
                state_d   = DIV;
            end
            DIV:  if (div_done) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_re_q      <= '0;
            a_im_q      <= '0;
            b_re_q      <= '0;
            b_im_q      <= '0;
            nre_neg_q   <= 1'b0;
            nim_neg_q   <= 1'b0;
            ovf_re_q    <= 1'b0;
            ovf_im_q    <= 1'b0;
            den_zero_q  <= 1'b0;
            Y_real      <= '0;
            Y_imag      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (state_q == IDLE && in_valid) begin
                a_re_q <= A_real;
                a_im_q <= A_imag;
                b_re_q <= B_real;
                b_im_q <= B_imag;
            end
            if (state_q == MULT) begin
                nre_neg_q  <= nre_c[PW-1];
                nim_neg_q  <= nim_c[PW-1];
                ovf_re_q   <= ovf_re_c;
                ovf_im_q   <= ovf_im_c;
                den_zero_q <= (den_c == '0);
            end
            // Result registers only load on completion, so they hold under backpressure.
            if (state_q == DIV && div_done) begin
                Y_real      <= y_re_c;
                Y_imag      <= y_im_c;
                div_by_zero <= den_zero_q;
            end
        end
    end

endmodule
